counter_trig_scheduler: RTL and testbench

// - Collects single-cycle event pulses from N counter channels (e.g. count==00/80/FF flags).
// - Shares one trigger-out endpoint among those channels:
//   - holds a pending flag per channel;
//   - issues pending events one at a time, round-robin, with a guaranteed minimum spacing.
// - Sits in the sys_clk domain between the counter channels and the okTriggerOut endpoint.

---
 rtl/counter_trig_scheduler_pkg.sv | 34 +++
 rtl/counter_trig_scheduler_if.sv | 29 ++
 rtl/counter_trig_scheduler_rr_pick.sv | 25 ++
 rtl/counter_trig_scheduler.sv | 117 +++++++++++
 tb/tb_counter_trig_scheduler.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_trig_scheduler_pkg.sv
// Shared types and helpers for the counter trigger scheduler: FSM state encoding,
// endpoint width and the circular round-robin search used by rr_pick.
package counters_pkg;

    localparam int TRIG_EP_W = 32;
    localparam int MAX_SRC   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // First set bit of req strictly after ptr, wrapping modulo n. Returns ptr when req is empty;
    // callers qualify the result with |req.
    function automatic logic [3:0] rr_next(input logic [3:0] ptr,
                                           input logic [MAX_SRC-1:0] req,
                                           input int n);
        logic [3:0] gnt;
        logic       found;
        int         idx;
        gnt   = ptr;
        found = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && !found && req[idx]) begin
                gnt   = 4'(idx);
                found = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/counter_trig_scheduler_if.sv
// Bundle between the counter channels / host wires (master) and the trigger scheduler (slave).
interface counter_trig_scheduler_if #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8
);
    import counters_pkg::*;

    // No handshake: src_event bits are single-cycle pulses that are always accepted; trig_out is a
    // one-hot single-cycle pulse with trig_src valid only while |trig_out. The rest are status levels.
    logic [N_SRC-1:0]         src_event;
    logic [N_SRC-1:0]         src_mask;
    logic [N_SRC-1:0]         trig_out;
    logic [$clog2(N_SRC)-1:0] trig_src;
    logic [N_SRC-1:0]         pending;
    logic [CNT_W-1:0]         drop_count;
    logic                     busy;
    state_t                   state_dbg;

    modport master (
        output src_event, src_mask,
        input  trig_out, trig_src, pending, drop_count, busy, state_dbg
    );

    modport slave (
        input  src_event, src_mask,
        output trig_out, trig_src, pending, drop_count, busy, state_dbg
    );

endinterface

// File: rtl/counter_trig_scheduler_rr_pick.sv
// Combinational round-robin selector: grants the first requesting source after ptr.
module rr_pick
    import counters_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]         req,
    input  logic [$clog2(N_SRC)-1:0] ptr,
    output logic [$clog2(N_SRC)-1:0] gnt_idx,
    output logic                     gnt_valid
);
    localparam int IDX_W = $clog2(N_SRC);

    logic [MAX_SRC-1:0] req_ext;
    logic [3:0]         pick;

    always_comb begin
        req_ext             = '0;
        req_ext[N_SRC-1:0]  = req;
        pick                = rr_next(4'(ptr), req_ext, N_SRC);
        gnt_idx             = IDX_W'(pick);
        gnt_valid           = |req;
    end

endmodule

// File: rtl/counter_trig_scheduler.sv
// Collects per-channel event pulses into pending flags and issues them one at a time,
// round-robin, onto a shared trigger-out endpoint with a minimum pulse spacing.
module counter_trig_scheduler
    import counters_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int SPACING = 2,
    parameter int CNT_W   = 8
) (
    input logic sys_clk,
    input logic reset,
    counter_trig_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(N_SRC);
    localparam int GAP_W = $clog2(SPACING) + 1;
    localparam int SUM_W = CNT_W + 5;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((SPACING >= 2) ? SPACING - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (N_SRC < 2 || N_SRC > MAX_SRC || N_SRC > TRIG_EP_W || SPACING < 1) begin : g_bad_param
        $error("counter_trig_scheduler: unsupported parameter combination");
    end

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [GAP_W-1:0] gap_cnt;
    logic [N_SRC-1:0] trig_out_q;
    logic [IDX_W-1:0] trig_src_q;
    logic [N_SRC-1:0] pending_q;
    logic [CNT_W-1:0] drop_q;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] issue_clear;
    logic [N_SRC-1:0] drop_bits;
    logic [N_SRC-1:0] pending_d;
    logic [SUM_W-1:0] drop_sum;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    assign req = pending_q & bus.src_mask;

    rr_pick #(.N_SRC(N_SRC)) u_pick (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // trig_out_q is exactly onehot(g) during ISSUE, so it doubles as the grant clear mask
    // without indexing by trig_src (safe for non-power-of-two N_SRC).
    always_comb begin
        issue_clear = (state == ISSUE) ? trig_out_q : '0;
        drop_bits   = bus.src_event & bus.src_mask & pending_q & ~issue_clear;
        pending_d   = bus.src_mask & ((pending_q & ~issue_clear) | bus.src_event);
        drop_sum    = SUM_W'(drop_q) + SUM_W'($countones(drop_bits));
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
        end
    end

    // The pulse is registered on the IDLE->ISSUE edge, so trig_out is high for the whole ISSUE cycle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= IDX_W'(N_SRC - 1);
            gap_cnt    <= '0;
            trig_out_q <= '0;
            trig_src_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        state      <= ISSUE;
                        trig_out_q <= N_SRC'(1) << gnt_idx;
                        trig_src_q <= gnt_idx;
                    end
                end
                ISSUE: begin
                    trig_out_q <= '0;
                    rr_ptr     <= trig_src_q;
                    if (SPACING == 1) begin
                        state <= IDLE;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= GAP_INIT;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    trig_out_q <= '0;
                end
            endcase
        end
    end

    assign bus.trig_out   = trig_out_q;
    assign bus.trig_src   = trig_src_q;
    assign bus.pending    = pending_q;
    assign bus.drop_count = drop_q;
    assign bus.busy       = (state != IDLE) || (|pending_q);
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_counter_trig_scheduler.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model of the scheduler.
module tb_counter_trig_scheduler;
    import counters_pkg::*;

    localparam int N       = 4;
    localparam int SPACING = 2;
    localparam int CNT_W   = 8;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    int checks = 0;
    int errors = 0;

    counter_trig_scheduler_if #(.N_SRC(N), .CNT_W(CNT_W)) bus ();

    counter_trig_scheduler #(.N_SRC(N), .SPACING(SPACING), .CNT_W(CNT_W)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.src_event = '0;
        bus.src_mask  = '1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.src_event = '0;
        bus.src_mask  = '1;
        reset         = 1'b1;
        tick();
        tick();
        checks += 5;
        if (bus.trig_out !== '0) begin errors++; $display("FAIL reset_trig_out: got %b want 0", bus.trig_out); end
        if (bus.trig_src !== '0) begin errors++; $display("FAIL reset_trig_src: got %0d want 0", bus.trig_src); end
        if (bus.pending !== '0) begin errors++; $display("FAIL reset_pending: got %b want 0", bus.pending); end
        if (bus.drop_count !== '0) begin errors++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        tick();
        bus.src_event = 4'b0100;
        tick();
        bus.src_event = '0;
        checks += 2;
        if (bus.pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b want 0100", bus.pending); end
        if (bus.trig_out !== '0) begin errors++; $display("FAIL single_early: got %b want 0000", bus.trig_out); end
        tick();
        checks += 2;
        if (bus.trig_out !== 4'b0100) begin errors++; $display("FAIL single_trig_out: got %b want 0100", bus.trig_out); end
        if (bus.trig_src !== 2'd2) begin errors++; $display("FAIL single_trig_src: got %0d want 2", bus.trig_src); end
        tick();
        checks += 3;
        if (bus.pending !== '0) begin errors++; $display("FAIL single_clear: got %b want 0000", bus.pending); end
        if (bus.trig_out !== '0) begin errors++; $display("FAIL single_one_cycle: got %b want 0000", bus.trig_out); end
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_gap: got %b want 1", bus.busy); end
    endtask

    task automatic test_three();
        logic [1:0] exp_q[$];
        int         last_cyc;
        int         pulses;
        logic [1:0] want;
        exp_q    = '{2'd0, 2'd1, 2'd3};
        last_cyc = -1;
        pulses   = 0;
        do_reset();
        bus.src_event = 4'b1011;
        tick();
        bus.src_event = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (|bus.trig_out) begin
                pulses++;
                checks += 2;
                if (bus.trig_out !== (N'(1) << bus.trig_src)) begin
                    errors++; $display("FAIL three_onehot: got %b src %0d", bus.trig_out, bus.trig_src);
                end
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL three_extra: got src %0d want no pulse", bus.trig_src);
                end else begin
                    want = exp_q.pop_front();
                    if (bus.trig_src !== want) begin errors++; $display("FAIL three_order: got %0d want %0d", bus.trig_src, want); end
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (c - last_cyc != 3) begin errors++; $display("FAIL three_spacing: got %0d want 3", c - last_cyc); end
                end
                last_cyc = c;
            end
        end
        checks += 2;
        if (pulses != 3) begin errors++; $display("FAIL three_count: got %0d want 3", pulses); end
        if (bus.drop_count !== '0) begin errors++; $display("FAIL three_drop: got %0d want 0", bus.drop_count); end
    endtask

    task automatic test_drop();
        int src1_pulses;
        src1_pulses = 0;
        do_reset();
        bus.src_event = 4'b0011;
        tick();
        bus.src_event = '0;
        tick();
        checks++;
        if (bus.trig_out !== 4'b0001) begin errors++; $display("FAIL drop_issue0: got %b want 0001", bus.trig_out); end
        bus.src_event = 4'b0010;
        tick();
        bus.src_event = '0;
        checks++;
        if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL drop_count: got %0d want 1", bus.drop_count); end
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.trig_out[1]) src1_pulses++;
        end
        checks += 2;
        if (src1_pulses != 1) begin errors++; $display("FAIL drop_src1_pulses: got %0d want 1", src1_pulses); end
        if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL drop_count_final: got %0d want 1", bus.drop_count); end
    endtask

    task automatic test_mask();
        logic [CNT_W-1:0] drop0;
        int               seen;
        seen = 0;
        do_reset();
        bus.src_event = 4'b1001;
        tick();
        bus.src_event = '0;
        tick();
        tick();
        drop0 = bus.drop_count;
        checks++;
        if (bus.pending !== 4'b1000) begin errors++; $display("FAIL mask_pre_pending: got %b want 1000", bus.pending); end
        bus.src_mask = 4'b0111;
        tick();
        checks++;
        if (bus.pending !== '0) begin errors++; $display("FAIL mask_clear: got %b want 0000", bus.pending); end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (|bus.trig_out) seen++;
        end
        bus.src_mask = '1;
        checks += 2;
        if (seen != 0) begin errors++; $display("FAIL mask_no_trig: got %0d pulses want 0", seen); end
        if (bus.drop_count !== drop0) begin errors++; $display("FAIL mask_drop: got %0d want %0d", bus.drop_count, drop0); end
    endtask

    task automatic test_reset_issue();
        do_reset();
        bus.src_event = 4'b0100;
        tick();
        bus.src_event = '0;
        tick();
        checks++;
        if (bus.trig_out !== 4'b0100) begin errors++; $display("FAIL rst_issue_pre: got %b want 0100", bus.trig_out); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 4;
        if (bus.trig_out !== '0) begin errors++; $display("FAIL rst_issue_trig: got %b want 0000", bus.trig_out); end
        if (bus.trig_src !== '0) begin errors++; $display("FAIL rst_issue_src: got %0d want 0", bus.trig_src); end
        if (bus.pending !== '0) begin errors++; $display("FAIL rst_issue_pending: got %b want 0000", bus.pending); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_issue_busy: got %b want 0", bus.busy); end
        bus.src_event = 4'b1001;
        tick();
        bus.src_event = '0;
        tick();
        checks += 2;
        if (bus.trig_out !== 4'b0001) begin errors++; $display("FAIL rst_issue_prio: got %b want 0001", bus.trig_out); end
        if (bus.trig_src !== 2'd0) begin errors++; $display("FAIL rst_issue_prio_src: got %0d want 0", bus.trig_src); end
    endtask

    task automatic test_round_robin();
        int   prev;
        int   grants;
        logic [1:0] want;
        prev   = -1;
        grants = 0;
        do_reset();
        bus.src_event = '1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (|bus.trig_out) begin
                want = (prev < 0) ? 2'd0 : 2'((prev + 1) % N);
                checks++;
                if (bus.trig_src !== want) begin errors++; $display("FAIL rr_order: got %0d want %0d", bus.trig_src, want); end
                prev = int'(bus.trig_src);
                grants++;
            end
        end
        checks++;
        if (grants < 12) begin errors++; $display("FAIL rr_grants: got %0d want >= 12", grants); end
        repeat (220) tick();
        bus.src_event = '0;
        checks++;
        if (bus.drop_count !== 8'hFF) begin errors++; $display("FAIL rr_saturate: got %0h want ff", bus.drop_count); end
        tick();
        checks++;
        if (bus.drop_count !== 8'hFF) begin errors++; $display("FAIL rr_no_wrap: got %0h want ff", bus.drop_count); end
    endtask

    // Model: per cycle, a decision may happen when no pulse is showing and at least SPACING cycles
    // have passed since the last pulse began; the pulse then appears in the following cycle.
    task automatic test_random();
        logic [N-1:0] m_pend, nxt_pend, ev, mk, exp_trig;
        int           m_grant, m_last, m_rr, m_drop, cyc, g, idx;
        logic         rst, exp_busy;
        m_pend  = '0; m_grant = -1; m_last = -1000; m_rr = N - 1; m_drop = 0; cyc = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 255) == 0);
            ev  = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            mk  = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '1;
            reset = rst; bus.src_event = ev; bus.src_mask = mk;
            if (rst) begin
                m_pend = '0; m_grant = -1; m_last = -1000; m_rr = N - 1; m_drop = 0;
            end else begin
                g = -1;
                if (m_grant < 0 && cyc >= m_last + SPACING) begin
                    for (int k = 1; k <= N; k++) begin
                        idx = (m_rr + k) % N;
                        if (g < 0 && m_pend[idx] && mk[idx]) g = idx;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (mk[i] && ev[i] && m_pend[i] && m_grant != i) m_drop++;
                    nxt_pend[i] = mk[i] && (ev[i] || (m_pend[i] && m_grant != i));
                end
                if (m_drop > 255) m_drop = 255;
                m_pend  = nxt_pend;
                m_grant = g;
                if (g >= 0) begin m_last = cyc + 1; m_rr = g; end
            end
            cyc++;
            tick();
            exp_trig = '0;
            if (m_grant >= 0) exp_trig[m_grant] = 1'b1;
            exp_busy = (m_grant >= 0) || (cyc < m_last + SPACING) || (|m_pend);
            checks += 4;
            if (bus.trig_out !== exp_trig) begin errors++; $display("FAIL rand_trig_out cyc %0d: got %b want %b", cyc, bus.trig_out, exp_trig); end
            if (bus.pending !== m_pend) begin errors++; $display("FAIL rand_pending cyc %0d: got %b want %b", cyc, bus.pending, m_pend); end
            if (bus.drop_count !== CNT_W'(m_drop)) begin errors++; $display("FAIL rand_drop cyc %0d: got %0d want %0d", cyc, bus.drop_count, m_drop); end
            if (bus.busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, bus.busy, exp_busy); end
            if (m_grant >= 0) begin
                checks++;
                if (int'(bus.trig_src) != m_grant) begin errors++; $display("FAIL rand_trig_src cyc %0d: got %0d want %0d", cyc, bus.trig_src, m_grant); end
            end
        end
        reset = 1'b0; bus.src_event = '0; bus.src_mask = '1;
    endtask

    initial begin
        bus.src_event = '0;
        bus.src_mask  = '1;
        test_reset();
        test_single();
        test_three();
        test_drop();
        test_mask();
        test_reset_issue();
        test_round_robin();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
